blink_period_meter: RTL and testbench

//  Receive-side counterpart of the LED blinker. Samples an asynchronous square-wave input, e.g. a blink or

---
 rtl/blink_pkg.sv | 18 +
 rtl/sig_sync_edge.sv | 100 ++++++++++
 rtl/blink_period_meter.sv | 177 +++++++++++++++++
 tb/tb_blink_period_meter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
//   Shared types and constants for the LED blinker and its receive-side
//   period meter.
//   - meter_state_t : phase-tracking state of blink_period_meter
//   - BLINK_CNT_W   : default counter / result field width
// -----------------------------------------------------------------------------
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meter_state_t;

  localparam int BLINK_CNT_W = 21;

endpackage

// File: rtl/sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
//   Brings an asynchronous level into the clk domain and produces registered
//   single-cycle rise/fall pulses. With BLINK_METER_FILTER_EN defined, a
//   deglitcher sits between the synchronizer and the edge detector: the level
//   only changes after FILT_LEN consecutive equal synchronized samples.
// Ports
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   sig_i    in  asynchronous input
//   level_o  out synchronized (optionally filtered) level
//   rise_o   out 1-cycle pulse on a 0->1 change of level_o
//   fall_o   out 1-cycle pulse on a 1->0 change of level_o
// Configuration macro: BLINK_METER_FILTER_EN
// -----------------------------------------------------------------------------
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_s;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer shift chain; sync_q[SYNC_STAGES-1] is the settled sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
    end
  end

`ifdef BLINK_METER_FILTER_EN
  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_lvl_q, filt_lvl_d;

  // Deglitcher: count consecutive samples that disagree with the accepted
  // level and flip on the FILT_LEN-th one; any agreeing sample restarts it.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_lvl_d = filt_lvl_q;
    if (sync_q[SYNC_STAGES-1] != filt_lvl_q) begin
      if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
        filt_lvl_d = sync_q[SYNC_STAGES-1];
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  // Deglitcher state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_q <= '0;
      filt_lvl_q <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      filt_lvl_q <= filt_lvl_d;
    end
  end

  assign level_s = filt_lvl_q;
`else
  assign level_s = sync_q[SYNC_STAGES-1];
`endif

  // Edge detector: the pulses are registered, so they appear one cycle after
  // the level itself changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= level_s;
      rise_q <= level_s & ~prev_q;
      fall_q <= ~level_s & prev_q;
    end
  end

  assign level_o = level_s;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/blink_period_meter.sv
// -----------------------------------------------------------------------------
// blink_period_meter
//   Measures the high and low phases of an asynchronous square wave in clk
//   ticks. Each complete period (rise -> fall -> rise) is published as one
//   {meas_high, meas_low} record over a valid/ready handshake.
// Ports
//   clk         in  clock
//   rst_n       in  asynchronous active-low reset
//   sig_in      in  asynchronous input signal
//   meas_valid  out record valid
//   meas_ready  in  consumer ready (transfer on valid && ready)
//   meas_high   out ticks high in the measured period
//   meas_low    out ticks low in the measured period
//   overrun     out sticky: a record was dropped since the last transfer
//   timeout     out no edge within TIMEOUT ticks; cleared by the next rise
//   sig_level   out synchronized (optionally filtered) input level
// Configuration macro: BLINK_METER_FILTER_EN (input deglitcher)
// -----------------------------------------------------------------------------
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int CNT_W       = BLINK_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**21 - 1,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low,
  output logic             overrun,
  output logic             timeout,
  output logic             sig_level
);

  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  logic rise_s, fall_s, level_s;

  sig_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_i   (sig_in),
    .level_o (level_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             tmo_q, tmo_d;
  logic             publish_s;
  logic             drop_s;
  logic             hs_s;

  // Next-state logic: phase FSM, counter, high-phase latch, output record.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    high_d    = high_q;
    low_d     = low_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    tmo_d     = tmo_q;
    publish_s = 1'b0;
    hs_s      = valid_q & meas_ready;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise_s) begin
          state_d = HIGH;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          tmo_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        // Timeout is checked first so the counter can never pass TIMEOUT.
        if (cnt_q == TMO_C) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else if (fall_s) begin
          state_d = LOW;
          hi_d    = cnt_q;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      LOW: begin
        if (cnt_q == TMO_C) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else if (rise_s) begin
          state_d   = HIGH;
          cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          publish_s = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A record is dropped only when the slot is full and not draining now;
    // a transfer in the same cycle frees the slot for the new record.
    drop_s = publish_s & valid_q & ~meas_ready;

    if (publish_s && !drop_s) begin
      high_d  = hi_q;
      low_d   = cnt_q;
      valid_d = 1'b1;
    end else if (hs_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (hs_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      high_q  <= '0;
      low_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      high_q  <= high_d;
      low_q   <= low_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign meas_valid = valid_q;
  assign meas_high  = high_q;
  assign meas_low   = low_q;
  assign overrun    = ovr_q;
  assign timeout    = tmo_q;
  assign sig_level  = level_s;

endmodule

// File: tb/tb_blink_period_meter.sv
// -----------------------------------------------------------------------------
// tb_blink_period_meter
//   Directed bench for blink_period_meter (CNT_W=21, SYNC_STAGES=2,
//   TIMEOUT=1000). sig_in and meas_ready change 1 time unit after a rising
//   clock edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_blink_period_meter;

`ifdef BLINK_METER_FILTER_EN
  localparam int LAT = 8;   // sig_in rise -> meas_valid, in cycles
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic        meas_ready;
  logic        meas_valid;
  logic [20:0] meas_high;
  logic [20:0] meas_low;
  logic        overrun;
  logic        timeout;
  logic        sig_level;

  int n_vec = 0;
  int n_err = 0;

  blink_period_meter #(
    .CNT_W       (21),
    .SYNC_STAGES (2),
    .TIMEOUT     (1000),
    .FILT_LEN    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_high  (meas_high),
    .meas_low   (meas_low),
    .overrun    (overrun),
    .timeout    (timeout),
    .sig_level  (sig_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a high phase of hi_len ticks (then low), checking that the
  // record {hi, lo} appears as a one-cycle pulse exactly LAT cycles after
  // the rise. Runs max(hi_len, LAT+1) cycles; needs meas_ready=1.
  task automatic rise_check(input int hi_len, input int hi, input int lo);
    int n;
    n = (hi_len > LAT + 1) ? hi_len : LAT + 1;
    sig_in = 1'b1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i == hi_len) sig_in = 1'b0;
      if (i == LAT - 1) chk("pre_valid", 32'(meas_valid), 32'd0);
      if (i == LAT) begin
        chk("rec_valid", 32'(meas_valid), 32'd1);
        chk("rec_high", 32'(meas_high), 32'(hi));
        chk("rec_low", 32'(meas_low), 32'(lo));
      end
      if (i == LAT + 1) chk("post_valid", 32'(meas_valid), 32'd0);
    end
  endtask

  initial begin
    // T1: reset with sig_in toggling.
    rst_n = 1'b0; sig_in = 1'b0; meas_ready = 1'b0;
    repeat (3) begin
      phase(1'b1, 2);
      phase(1'b0, 1);
    end
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_high", 32'(meas_high), 32'd0);
    chk("rst_low", 32'(meas_low), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_level", 32'(sig_level), 32'd0);
    rst_n = 1'b1;
    phase(1'b0, 10);
    chk("idle_valid", 32'(meas_valid), 32'd0);

    // T2: 37 high / 63 low, consumer always ready.
    meas_ready = 1'b1;
    phase(1'b1, 37);
    chk("t2_level_hi", 32'(sig_level), 32'd1);
    phase(1'b0, 63);
    chk("t2_first_nopub", 32'(meas_valid), 32'd0);
    rise_check(37, 37, 63);
    phase(1'b0, 63);
    rise_check(37, 37, 63);
    phase(1'b0, 63);

    // T3: backpressure over three periods.
    meas_ready = 1'b0;
    sig_in = 1'b1;
    repeat (LAT) step();
    chk("t3_valid", 32'(meas_valid), 32'd1);
    chk("t3_high", 32'(meas_high), 32'd37);
    chk("t3_low", 32'(meas_low), 32'd63);
    chk("t3_ovr_pre", 32'(overrun), 32'd0);
    repeat (37 - LAT) step();
    phase(1'b0, 50);
    phase(1'b1, 20);
    phase(1'b0, 30);
    phase(1'b1, 25);
    chk("t3_hold_valid", 32'(meas_valid), 32'd1);
    chk("t3_hold_high", 32'(meas_high), 32'd37);
    chk("t3_hold_low", 32'(meas_low), 32'd63);
    chk("t3_ovr_set", 32'(overrun), 32'd1);
    sig_in = 1'b0;
    repeat (10) step();
    chk("t3_ovr_sticky", 32'(overrun), 32'd1);
    meas_ready = 1'b1;
    step();
    chk("t3_hs_valid", 32'(meas_valid), 32'd0);
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    repeat (29) step();

    // T4: transfer in the same cycle as the next publish.
    meas_ready = 1'b0;
    sig_in = 1'b1;
    repeat (LAT) step();
    chk("t4_first_valid", 32'(meas_valid), 32'd1);
    chk("t4_first_high", 32'(meas_high), 32'd25);
    chk("t4_first_low", 32'(meas_low), 32'd40);
    repeat (30 - LAT) step();
    phase(1'b0, 45);
    sig_in = 1'b1;
    repeat (LAT - 1) step();
    meas_ready = 1'b1;
    step();
    chk("t4_sim_valid", 32'(meas_valid), 32'd1);
    chk("t4_sim_high", 32'(meas_high), 32'd30);
    chk("t4_sim_low", 32'(meas_low), 32'd45);
    chk("t4_sim_ovr", 32'(overrun), 32'd0);
    step();
    chk("t4_drain", 32'(meas_valid), 32'd0);
    repeat (30 - LAT - 1) step();
    phase(1'b0, 20);

    // T5: signal stuck high for 1500 ticks.
    phase(1'b1, 900);
    chk("t5_tmo_early", 32'(timeout), 32'd0);
    repeat (200) step();
    chk("t5_tmo_set", 32'(timeout), 32'd1);
    repeat (400) step();
    chk("t5_tmo_hold", 32'(timeout), 32'd1);
    chk("t5_no_rec", 32'(meas_valid), 32'd0);
    phase(1'b0, 30);
    chk("t5_tmo_fall", 32'(timeout), 32'd1);
    sig_in = 1'b1;
    repeat (LAT) step();
    chk("t5_tmo_clr", 32'(timeout), 32'd0);
    chk("t5_rise_nopub", 32'(meas_valid), 32'd0);
    repeat (10 - LAT + 2) step();
    phase(1'b0, 15);
    rise_check(12, 12, 15);

    // T6: 3-tick glitch, then a 4-tick pulse.
    phase(1'b0, 50);
`ifdef BLINK_METER_FILTER_EN
    phase(1'b1, 3);
    phase(1'b0, 50);
    chk("t6_glitch_ign", 32'(meas_valid), 32'd0);
    rise_check(4, 12, 103);
    phase(1'b0, 20 - (LAT + 1 - 4));
    rise_check(10, 4, 20);
`else
    rise_check(3, 12, 50);
    phase(1'b0, 50 - (LAT + 1 - 3));
    rise_check(4, 3, 50);
    phase(1'b0, 20 - (LAT + 1 - 4));
    rise_check(10, 4, 20);
`endif
    phase(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
